// File: rtl/q15_pkg.sv
// ---------------------------------------------------------------------------
// q15_pkg
// Shared constants for the Q15.48 fixed-point to IEEE-754 single conversion
// path. Imported by the converter, the arbiter and the top level.
//   Q15_W / Q15_FRAC : width and fraction bits of the signed Q15.48 operand
//   FP32_W           : width of the float result
//   Q15_POS_INF/NEG_INF : saturated fixed-point codes that map to +/-inf
//   FP32_POS_INF/NEG_INF : IEEE-754 single infinities
// ---------------------------------------------------------------------------
package q15_pkg;

  localparam int Q15_W    = 64;
  localparam int Q15_FRAC = 48;
  localparam int FP32_W   = 32;

  localparam logic [63:0] Q15_POS_INF = 64'h7fffffffffffffff;
  localparam logic [63:0] Q15_NEG_INF = 64'h8000000000000001;
  // Most negative code; one step below the negative saturation value.
  localparam logic [63:0] Q15_MIN     = 64'h8000000000000000;

  localparam logic [31:0] FP32_POS_INF = 32'h7f800000;
  localparam logic [31:0] FP32_NEG_INF = 32'hff800000;

  localparam int FP32_BIAS = 127;

  // Biased exponent for a leading one at bit 63 of the operand:
  // value 2^(63-48), biased by 127. Each leading zero lowers it by one.
  localparam int EXP_TOP = (Q15_W - 1 - Q15_FRAC) + FP32_BIAS;

endpackage

// File: rtl/q15_convert_arbiter_q15tofp32.sv
// ---------------------------------------------------------------------------
// Q15ToFp32
// Combinational conversion of a signed Q15.48 value to IEEE-754 single,
// rounding to nearest, ties to even. Saturated fixed-point codes become
// infinities; zero becomes +0.
//   q_in  : 64-bit signed Q15.48 operand
//   f_out : 32-bit fp32 result
// ---------------------------------------------------------------------------
module Q15ToFp32
  import q15_pkg::*;
(
  input  logic [Q15_W-1:0]  q_in,
  output logic [FP32_W-1:0] f_out
);

  logic              sign;
  logic [Q15_W-1:0]  mag;
  logic [6:0]        lz;
  logic [62:0]       norm;
  logic [7:0]        exp_pre;
  logic              round_up;
  logic [30:0]       mag_bits;

  always_comb begin
    sign = q_in[Q15_W-1];
    mag  = sign ? (~q_in + 64'd1) : q_in;

    // Highest set bit wins because later iterations overwrite earlier ones.
    lz = 7'd0;
    for (int i = 0; i < Q15_W; i++) begin
      if (mag[i]) lz = 7'(Q15_W - 1 - i);
    end

    // After the shift the leading one sits at bit 63 and is dropped,
    // so norm holds the fraction, guard and sticky bits.
    norm     = 63'(mag << lz);
    exp_pre  = 8'(EXP_TOP) - 8'(lz);
    round_up = norm[39] && ((|norm[38:0]) || norm[40]);

    // A mantissa carry out of rounding ripples into the exponent field.
    mag_bits = {exp_pre, norm[62:40]} + 31'(round_up);

    if (q_in == '0) begin
      f_out = '0;
    end else if (q_in == Q15_POS_INF) begin
      f_out = FP32_POS_INF;
    end else if (q_in == Q15_NEG_INF || q_in == Q15_MIN) begin
      f_out = FP32_NEG_INF;
    end else begin
      f_out = {sign, mag_bits};
    end
  end

endmodule

// File: rtl/q15_convert_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: the first asserted request found searching
// upward from ptr, wrapping from NREQ-1 to 0. The pointer register itself
// lives in the parent.
//   req     : request vector
//   ptr     : index to start searching from
//   en      : grants are suppressed when low
//   gnt     : one-hot (or zero) grant
//   gnt_idx : index of the granted request, 0 when nothing is granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/q15_convert_arbiter.sv
// ---------------------------------------------------------------------------
// q15_convert_arbiter
// Shares one Q15ToFp32 converter between NREQ requesters with round-robin
// arbitration. The converted value is registered with the winner's ID.
//   clk, rst_n : clock and synchronous active-low reset
//   req_valid  : per-requester valid
//   req_data   : requester i operand in bits [64*i+63:64*i]
//   req_ready  : one-hot accept, combinational
//   out_valid  : result register holds a valid result
//   out_data   : fp32 result
//   out_id     : requester index that produced out_data
//   out_ready  : downstream accepts the result
// ---------------------------------------------------------------------------
module q15_convert_arbiter
  import q15_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*Q15_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [FP32_W-1:0]     out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready
);

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [FP32_W-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]    out_id_q, out_id_d;

  logic              can_accept;
  logic              arb_en;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              fire;
  logic [Q15_W-1:0]  sel_data;
  logic [FP32_W-1:0] conv_out;

  // The result register can take a new value when it is empty or being
  // drained this cycle. Grants are held off during reset so nothing is
  // accepted until rst_n has risen.
  assign can_accept = !out_valid_q || out_ready;
  assign arb_en     = rst_n && can_accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign fire      = |gnt;

  // Operand mux in front of the single shared converter.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(gnt_idx) == i) sel_data = req_data[i*Q15_W +: Q15_W];
    end
  end

  Q15ToFp32 u_conv (
    .q_in  (sel_data),
    .f_out (conv_out)
  );

  // A new grant overwrites the result register even when the old result is
  // draining in the same cycle, which keeps out_valid high back to back.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_out;
      out_id_d    = gnt_idx;
      rr_ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_q15_convert_arbiter.sv
// ---------------------------------------------------------------------------
// tb_q15_convert_arbiter
// Directed, table-driven bench for q15_convert_arbiter with NREQ = 4.
// Each table row is one clock cycle: inputs, expected req_ready before the
// edge and expected output register contents after it.
// ---------------------------------------------------------------------------
module tb_q15_convert_arbiter;

  localparam logic [63:0] D_ZERO   = 64'h0000000000000000;
  localparam logic [63:0] D_HALF   = 64'h0000800000000000;
  localparam logic [63:0] D_ONE    = 64'h0001000000000000;
  localparam logic [63:0] D_TWO    = 64'h0002000000000000;
  localparam logic [63:0] D_NEG1   = 64'hffff000000000000;
  localparam logic [63:0] D_PINF   = 64'h7fffffffffffffff;
  localparam logic [63:0] D_NINF   = 64'h8000000000000001;
  localparam logic [63:0] D_NEGLSB = 64'hffffffffffffffff;
  localparam logic [63:0] D_POSLSB = 64'h0000000000000001;
  localparam logic [63:0] D_TIE    = 64'h0000000001000001;
  localparam logic [63:0] D_RUP    = 64'h0000000001000003;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
  logic         out_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] d0, d1, d2, d3;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  q15_convert_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3, input logic ordy,
                              input logic [3:0] exp_rdy, input logic exp_vld,
                              input logic [31:0] exp_data, input logic [1:0] exp_id);
    vec_t v;
    v.valid = valid; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_vld = exp_vld; v.exp_data = exp_data; v.exp_id = exp_id;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    req_valid = v.valid;
    req_data  = {v.d3, v.d2, v.d1, v.d0};
    out_ready = v.ordy;
  endtask

  task automatic check_output(input vec_t v, input int row);
    check($sformatf("row%0d out_valid", row), 64'(out_valid), 64'(v.exp_vld));
    if (v.exp_vld) begin
      check($sformatf("row%0d out_data", row), 64'(out_data), 64'(v.exp_data));
      check($sformatf("row%0d out_id", row), 64'(out_id), 64'(v.exp_id));
    end
  endtask

  initial begin
    // Fairness: all four valid, ready high -> ids 0,1,2,3,0
    vecs.push_back(mk(4'b1111, D_HALF, D_TWO, D_NEG1, D_ZERO, 1'b1, 4'b0001, 1'b1, 32'h3f000000, 2'd0));
    vecs.push_back(mk(4'b1111, D_HALF, D_TWO, D_NEG1, D_ZERO, 1'b1, 4'b0010, 1'b1, 32'h40000000, 2'd1));
    vecs.push_back(mk(4'b1111, D_HALF, D_TWO, D_NEG1, D_ZERO, 1'b1, 4'b0100, 1'b1, 32'hbf800000, 2'd2));
    vecs.push_back(mk(4'b1111, D_HALF, D_TWO, D_NEG1, D_ZERO, 1'b1, 4'b1000, 1'b1, 32'h00000000, 2'd3));
    vecs.push_back(mk(4'b1111, D_HALF, D_TWO, D_NEG1, D_ZERO, 1'b1, 4'b0001, 1'b1, 32'h3f000000, 2'd0));
    // Single request 1.0 from requester 0 (pointer at 1 wraps to 0)
    vecs.push_back(mk(4'b0001, D_ONE, D_ZERO, D_ZERO, D_ZERO, 1'b1, 4'b0001, 1'b1, 32'h3f800000, 2'd0));
    vecs.push_back(mk(4'b0000, D_ZERO, D_ZERO, D_ZERO, D_ZERO, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0));
    // Backpressure: +inf from req1 captured, then held for 3 stalled cycles
    vecs.push_back(mk(4'b0010, D_ZERO, D_PINF, D_ZERO, D_ZERO, 1'b0, 4'b0010, 1'b1, 32'h7f800000, 2'd1));
    for (int s = 0; s < 3; s++)
      vecs.push_back(mk(4'b1111, D_HALF, D_PINF, D_NEG1, D_NINF, 1'b0, 4'b0000, 1'b1, 32'h7f800000, 2'd1));
    // Release: next grant is req2, then req3 gives -inf
    vecs.push_back(mk(4'b1111, D_HALF, D_PINF, D_NEG1, D_NINF, 1'b1, 4'b0100, 1'b1, 32'hbf800000, 2'd2));
    vecs.push_back(mk(4'b1111, D_HALF, D_PINF, D_NEG1, D_NINF, 1'b1, 4'b1000, 1'b1, 32'hff800000, 2'd3));
    // Smallest negative magnitude through requester 2
    vecs.push_back(mk(4'b0100, D_ZERO, D_ZERO, D_NEGLSB, D_ZERO, 1'b1, 4'b0100, 1'b1, 32'ha7800000, 2'd2));
    vecs.push_back(mk(4'b0000, D_ZERO, D_ZERO, D_ZERO, D_ZERO, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0));
    // Rounding: exact tie rounds to even, above-half rounds up, smallest positive
    vecs.push_back(mk(4'b0001, D_TIE, D_ZERO, D_ZERO, D_ZERO, 1'b1, 4'b0001, 1'b1, 32'h33800000, 2'd0));
    vecs.push_back(mk(4'b0001, D_RUP, D_ZERO, D_ZERO, D_ZERO, 1'b1, 4'b0001, 1'b1, 32'h33800002, 2'd0));
    vecs.push_back(mk(4'b0001, D_POSLSB, D_ZERO, D_ZERO, D_ZERO, 1'b1, 4'b0001, 1'b1, 32'h27800000, 2'd0));
    vecs.push_back(mk(4'b0000, D_ZERO, D_ZERO, D_ZERO, D_ZERO, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0));

    // Reset with requests present: nothing accepted, registers cleared
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = {D_ZERO, D_NEG1, D_TWO, D_HALF};
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'h0);
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data", 64'(out_data), 64'h0);
    check("reset out_id", 64'(out_id), 64'h0);
    check("reset rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    foreach (vecs[r]) begin
      @(negedge clk);
      apply_stimulus(vecs[r]);
      #1;
      check($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(vecs[r].exp_rdy));
      @(posedge clk);
      #1;
      check_output(vecs[r], r);
    end

    // Drain and accept every cycle: 8 results in 8 cycles, pointer starts at 1
    @(negedge clk);
    req_valid = 4'b1111;
    req_data  = {D_ZERO, D_NEG1, D_TWO, D_HALF};
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d out_valid", n), 64'(out_valid), 64'h1);
      check($sformatf("b2b%0d out_id", n), 64'(out_id), 64'((n + 1) % 4));
    end

    // Stall with a pending result, then reset during the stall
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("stall req_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    check("stall out_valid", 64'(out_valid), 64'h1);
    check("stall out_id", 64'(out_id), 64'h0);

    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b0100;
    req_data  = {D_ZERO, D_ONE, D_ZERO, D_ZERO};
    #1;
    check("midrst req_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    check("midrst out_valid", 64'(out_valid), 64'h0);
    check("midrst rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("postrst req_ready", 64'(req_ready), 64'h4);
    @(posedge clk);
    #1;
    check("postrst out_valid", 64'(out_valid), 64'h1);
    check("postrst out_id", 64'(out_id), 64'h2);
    check("postrst out_data", 64'(out_data), 64'h3f800000);
    check("postrst rr_ptr", 64'(dut.rr_ptr_q), 64'h3);

    @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
